// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - shared encodings for the pipeline trace buffer
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_t;

  // Mode 3 is reserved and decodes the same as TRIG_EXT.
  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_EXT = 2'd1;
  localparam logic [1:0] TRIG_CMP = 2'd2;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port sample store, sync write, registered read
module trace_ram #(
  parameter int SAMPLE_W = 64,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Storage array: no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register only updates on a real read so the last value is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - triggered circular capture of pipeline snapshots
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int SAMPLE_W = 64,
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 8,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                clear,
  input  logic [1:0]          trig_mode,
  input  logic                trig_in,
  input  logic [SAMPLE_W-1:0] trig_value,
  input  logic [SAMPLE_W-1:0] trig_mask,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_empty,
  output logic [1:0]          state,
  output logic [ADDR_W:0]     count,
  output logic [ADDR_W-1:0]   trig_idx
);

  localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   PRE_CNT  = (ADDR_W+1)'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_IDX  = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W:0]   POST_LEN = (ADDR_W+1)'(DEPTH - PRE_TRIG - 1);

  trace_state_t        cur_st, nxt_st;
  logic [ADDR_W-1:0]   wptr, rptr;
  logic [ADDR_W:0]     unread, post_rem;
  logic                hit, wr_fire, trig_fire, rd_fire, done_entry, arm_ok;
  logic [ADDR_W-1:0]   wptr_nxt;
  logic [ADDR_W:0]     count_nxt;

  assign state    = cur_st;
  assign rd_empty = (cur_st != ST_DONE) || (unread == '0);

  // Trigger qualifier for the current sample, by mode.
  always_comb begin
    hit = 1'b0;
    case (trig_mode)
      TRIG_IMM: hit = 1'b1;
      TRIG_CMP: hit = ((sample_data ^ trig_value) & trig_mask) == '0;
      default:  hit = trig_in;
    endcase
  end

  assign arm_ok     = arm && ((cur_st == ST_IDLE) || (cur_st == ST_DONE));
  assign wr_fire    = reset && !clear && sample_valid &&
                      ((cur_st == ST_PRE) || (cur_st == ST_POST));
  assign trig_fire  = wr_fire && (cur_st == ST_PRE) && hit;
  assign rd_fire    = !clear && !arm && (cur_st == ST_DONE) && rd_en && (unread != '0);
  assign wptr_nxt   = wptr + 1'b1;
  assign count_nxt  = (count == FULL) ? count : count + 1'b1;
  assign done_entry = (nxt_st == ST_DONE) && (cur_st != ST_DONE);

  // Capture state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // Next-state logic; clear overrides everything, arm only acts when idle or done.
  always_comb begin
    nxt_st = cur_st;
    if (clear) begin
      nxt_st = ST_IDLE;
    end else begin
      case (cur_st)
        ST_IDLE: if (arm) nxt_st = ST_PRE;
        ST_PRE: begin
          if (trig_fire) nxt_st = (POST_LEN == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: if (wr_fire && (post_rem == 1)) nxt_st = ST_DONE;
        ST_DONE: if (arm) nxt_st = ST_PRE;
        default: nxt_st = ST_IDLE;
      endcase
    end
  end

  // Write/read pointers, fill level, trigger position and remaining post count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      unread   <= '0;
      post_rem <= '0;
      trig_idx <= '0;
      rd_valid <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      unread   <= '0;
      post_rem <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (arm_ok) begin
        wptr   <= '0;
        count  <= '0;
        unread <= '0;
      end
      if (wr_fire) begin
        wptr  <= wptr_nxt;
        count <= count_nxt;
      end
      if (trig_fire) begin
        trig_idx <= (count < PRE_CNT) ? count[ADDR_W-1:0] : PRE_IDX;
        post_rem <= POST_LEN;
      end else if (wr_fire && (cur_st == ST_POST)) begin
        post_rem <= post_rem - 1'b1;
      end
      // A full buffer has wrapped, so its oldest sample sits at the write pointer.
      if (done_entry) begin
        rptr   <= (count_nxt == FULL) ? wptr_nxt : '0;
        unread <= count_nxt;
      end
      if (rd_fire) begin
        rptr   <= rptr + 1'b1;
        unread <= unread - 1'b1;
      end
    end
  end

  trace_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_addr (wptr),
    .wr_data (sample_data),
    .rd_en   (rd_fire),
    .rd_addr (rptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - directed self-checking bench for pipe_trace_buffer
module tb_pipe_trace_buffer;

  localparam int SW = 64;
  localparam int DP = 8;
  localparam int PT = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          clear = 1'b0;
  logic [1:0]    trig_mode = 2'd0;
  logic          trig_in = 1'b0;
  logic [SW-1:0] trig_value = '0;
  logic [SW-1:0] trig_mask = '0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          rd_en = 1'b0;
  logic [SW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_empty;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic [AW-1:0] trig_idx;

  int checks = 0;
  int errors = 0;

  pipe_trace_buffer #(
    .SAMPLE_W (SW),
    .DEPTH    (DP),
    .PRE_TRIG (PT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .clear        (clear),
    .trig_mode    (trig_mode),
    .trig_in      (trig_in),
    .trig_value   (trig_value),
    .trig_mask    (trig_mask),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_empty     (rd_empty),
    .state        (state),
    .count        (count),
    .trig_idx     (trig_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held with arm asserted
    reset = 1'b0;
    arm   = 1'b1;
    step();
    step();
    chk("rst_state", state, 2'd0);
    chk("rst_count", count, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    reset = 1'b1;
    arm   = 1'b0;
    step();
    chk("idle_hold", state, 2'd0);

    // mode 1: trigger with sample 10
    trig_mode = 2'd1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("m1_pre", state, 2'd1);
    chk("m1_cnt0", count, 0);
    chk("m1_empty", rd_empty, 1);
    for (int i = 1; i <= 20; i++) begin
      sample_valid = 1'b1;
      sample_data  = SW'(i);
      trig_in      = (i == 10);
      step();
      if (i == 9)  chk("m1_pre_before", state, 2'd1);
      if (i == 10) chk("m1_post", state, 2'd2);
      if (i == 12) chk("m1_post12", state, 2'd2);
      if (i == 13) chk("m1_done", state, 2'd3);
    end
    sample_valid = 1'b0;
    trig_in      = 1'b0;
    chk("m1_count", count, 8);
    chk("m1_tidx", trig_idx, 4);
    chk("m1_notempty", rd_empty, 0);
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1;
      step();
      chk("m1_rvalid", rd_valid, 1);
      chk("m1_rdata", rd_data, SW'(6 + k));
    end
    chk("m1_empty_end", rd_empty, 1);
    for (int k = 0; k < 2; k++) begin
      rd_en = 1'b1;
      step();
      chk("over_valid", rd_valid, 0);
      chk("over_hold", rd_data, SW'(13));
    end
    rd_en = 1'b0;

    // mode 2: masked compare, re-armed from DONE
    trig_mode  = 2'd2;
    trig_value = SW'(64'h40);
    trig_mask  = SW'(64'hFF);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("rearm_pre", state, 2'd1);
    chk("rearm_empty", rd_empty, 1);
    chk("rearm_cnt", count, 0);
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_data  = SW'(64'h40 + i);
      step();
      if (i == 0) chk("m2_post", state, 2'd2);
      if (i == 3) chk("m2_done", state, 2'd3);
    end
    sample_valid = 1'b0;
    chk("m2_count", count, 4);
    chk("m2_tidx", trig_idx, 0);
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      step();
      chk("m2_rvalid", rd_valid, 1);
      chk("m2_rdata", rd_data, SW'(64'h40 + k));
    end
    rd_en = 1'b0;
    step();
    chk("m2_rvalid_off", rd_valid, 0);
    chk("m2_empty", rd_empty, 1);

    // mode 1 with gaps: trig_in only on invalid cycles
    trig_mode = 2'd1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sample_valid = (c % 2 == 0);
      sample_data  = SW'(16 + c);
      trig_in      = (c % 2 == 1);
      step();
    end
    chk("gap_pre", state, 2'd1);
    chk("gap_cnt", count, 5);
    sample_valid = 1'b1;
    sample_data  = SW'(64'h20);
    trig_in      = 1'b1;
    step();
    sample_valid = 1'b0;
    trig_in      = 1'b0;
    chk("gap_post", state, 2'd2);
    chk("gap_tidx", trig_idx, 4);

    // abort from POST, then arm+clear together
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("abort_state", state, 2'd0);
    chk("abort_cnt", count, 0);
    chk("abort_empty", rd_empty, 1);
    arm   = 1'b1;
    clear = 1'b1;
    step();
    arm   = 1'b0;
    clear = 1'b0;
    chk("armclr_state", state, 2'd0);

    // mode 0: idle cycles, immediate trigger, arm ignored in POST
    trig_mode = 2'd0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    chk("m0_wait", state, 2'd1);
    sample_valid = 1'b1;
    sample_data  = SW'(64'hA0);
    step();
    chk("m0_post", state, 2'd2);
    chk("m0_tidx", trig_idx, 0);
    arm = 1'b1;
    sample_data = SW'(64'hA1);
    step();
    arm = 1'b0;
    chk("m0_arm_ign", state, 2'd2);
    chk("m0_cnt2", count, 2);
    sample_data = SW'(64'hA2);
    step();
    sample_data = SW'(64'hA3);
    step();
    sample_valid = 1'b0;
    chk("m0_done", state, 2'd3);
    chk("m0_cnt", count, 4);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("m0_rdata", rd_data, SW'(64'hA0));

    // reset in DONE discards everything
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst2_state", state, 2'd0);
    chk("rst2_cnt", count, 0);
    chk("rst2_data", rd_data, 0);
    chk("rst2_empty", rd_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
